// File: rtl/gamma_lut_mc.sv
// Time-multiplexed gamma correction: NUM_CH channels per pixel share one LUT read port.
// The page and bypass selection are taken only on the first pixel of a frame (vsync falling).
module gamma_lut_mc #(
    parameter int COLOR_W   = 7,
    parameter int NUM_CH    = 3,
    parameter int SYNC_W    = 4,
    parameter int PAGE_W    = 3,
    parameter int VSYNC_BIT = 3
) (
    input  logic                             VCLK,
    input  logic                             RST,
    input  logic                             gamma_en_i,
    input  logic [PAGE_W-1:0]                gamma_page_i,
    input  logic                             lut_we_i,
    input  logic [PAGE_W+COLOR_W-1:0]        lut_addr_i,
    input  logic [COLOR_W-1:0]               lut_data_i,
    input  logic                             vdata_valid_i,
    input  logic [SYNC_W+NUM_CH*COLOR_W-1:0] vdata_i,
    output logic                             vdata_valid_o,
    output logic [SYNC_W+NUM_CH*COLOR_W-1:0] vdata_o,
    output logic                             overrun_o
);

    localparam int PIX_W = SYNC_W + NUM_CH * COLOR_W;
    localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LAST  = NUM_CH - 1;
    localparam int DEPTH = 2 ** (PAGE_W + COLOR_W);

    logic [PIX_W-1:0]   pix_q;
    logic               busy;
    logic [CNT_W-1:0]   cnt;
    logic               iss_last;
    logic [COLOR_W-1:0] iss_idx;

    logic               prev_vsync;
    logic               active_en;
    logic [PAGE_W-1:0]  active_page;
    logic               in_vsync;

    logic [COLOR_W-1:0] mem [DEPTH];

    logic               s1_valid, s1_last, s1_en;
    logic [CNT_W-1:0]   s1_ch;
    logic [COLOR_W-1:0] s1_raw, s1_lut;
    logic [SYNC_W-1:0]  s1_sync;

    logic               s2_valid, s2_last;
    logic [CNT_W-1:0]   s2_ch;
    logic [COLOR_W-1:0] s2_data;
    logic [SYNC_W-1:0]  s2_sync;

    logic [COLOR_W-1:0] asm_ch [NUM_CH];
    logic [PIX_W-1:0]   out_word;

    assign iss_last = (cnt == CNT_W'(LAST));
    assign in_vsync = vdata_i[NUM_CH*COLOR_W + VSYNC_BIT];

    // The pixel is captured on the pulse so vdata_i may move on while later channels are read.
    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            pix_q     <= '0;
            busy      <= 1'b0;
            cnt       <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (vdata_valid_i && busy && !iss_last)
                overrun_o <= 1'b1;
            if (vdata_valid_i) begin
                pix_q <= vdata_i;
                busy  <= 1'b1;
                cnt   <= '0;
            end else if (busy) begin
                if (iss_last)
                    busy <= 1'b0;
                else
                    cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            prev_vsync  <= 1'b0;
            active_en   <= 1'b0;
            active_page <= '0;
        end else if (vdata_valid_i) begin
            prev_vsync <= in_vsync;
            if (!in_vsync && prev_vsync) begin
                active_en   <= gamma_en_i;
                active_page <= gamma_page_i;
            end
        end
    end

    always_comb begin
        iss_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cnt == CNT_W'(k))
                iss_idx = pix_q[(NUM_CH-1-k)*COLOR_W +: COLOR_W];
        end
    end

    // RAM is never reset; the array read happens on the same edge as a write, so a
    // colliding read sees the old word.
    always_ff @(posedge VCLK) begin
        if (lut_we_i)
            mem[lut_addr_i] <= lut_data_i;
    end

    always_ff @(posedge VCLK) begin
        s1_lut <= mem[{active_page, iss_idx}];
    end

    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_en    <= 1'b0;
            s1_ch    <= '0;
            s1_raw   <= '0;
            s1_sync  <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_ch    <= '0;
            s2_data  <= '0;
            s2_sync  <= '0;
        end else begin
            s1_valid <= busy;
            s1_last  <= busy && iss_last;
            s1_en    <= active_en;
            s1_ch    <= cnt;
            s1_raw   <= iss_idx;
            s1_sync  <= pix_q[PIX_W-1 -: SYNC_W];
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_ch    <= s1_ch;
            s2_data  <= s1_en ? s1_lut : s1_raw;
            s2_sync  <= s1_sync;
        end
    end

    always_comb begin
        out_word = '0;
        out_word[PIX_W-1 -: SYNC_W] = s2_sync;
        for (int k = 0; k < NUM_CH; k++) begin
            if (k == LAST)
                out_word[(NUM_CH-1-k)*COLOR_W +: COLOR_W] = s2_data;
            else
                out_word[(NUM_CH-1-k)*COLOR_W +: COLOR_W] = asm_ch[k];
        end
    end

    // Channels of an aborted pixel may land here, but the next pixel overwrites every slot.
    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NUM_CH; k++)
                asm_ch[k] <= '0;
            vdata_valid_o <= 1'b0;
            vdata_o       <= '0;
        end else begin
            vdata_valid_o <= s2_valid && s2_last;
            if (s2_valid)
                asm_ch[s2_ch] <= s2_data;
            if (s2_valid && s2_last)
                vdata_o <= out_word;
        end
    end

endmodule

// File: tb/tb_gamma_lut_mc.sv
// Directed scoreboard bench for gamma_lut_mc: page 2 holds idx^7F, page 5 holds idx+1.
module tb_gamma_lut_mc;

    logic        VCLK;
    logic        RST;
    logic        gamma_en_i;
    logic [2:0]  gamma_page_i;
    logic        lut_we_i;
    logic [9:0]  lut_addr_i;
    logic [6:0]  lut_data_i;
    logic        vdata_valid_i;
    logic [24:0] vdata_i;
    logic        vdata_valid_o;
    logic [24:0] vdata_o;
    logic        overrun_o;

    typedef struct {
        logic [24:0] word;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    gamma_lut_mc dut (
        .VCLK          (VCLK),
        .RST           (RST),
        .gamma_en_i    (gamma_en_i),
        .gamma_page_i  (gamma_page_i),
        .lut_we_i      (lut_we_i),
        .lut_addr_i    (lut_addr_i),
        .lut_data_i    (lut_data_i),
        .vdata_valid_i (vdata_valid_i),
        .vdata_i       (vdata_i),
        .vdata_valid_o (vdata_valid_o),
        .vdata_o       (vdata_o),
        .overrun_o     (overrun_o)
    );

    initial begin
        VCLK = 1'b0;
        forever #5 VCLK = ~VCLK;
    end

    always @(posedge VCLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge VCLK);
        #1;
    endtask

    function automatic logic [24:0] pix(input logic [3:0] s, input logic [6:0] r,
                                        input logic [6:0] g, input logic [6:0] b);
        return {s, r, g, b};
    endfunction

    // One valid pulse; the next pulse from a following call lands 'gap' cycles later.
    task automatic applyStimulus(input logic [24:0] word, input bit expect_out,
                                 input logic [24:0] exp_word, input int gap);
        exp_t e;
        tick();
        vdata_i       = word;
        vdata_valid_i = 1'b1;
        if (expect_out) begin
            e.word = exp_word;
            e.cyc  = cyc + 6;
            exp_q.push_back(e);
        end
        tick();
        vdata_valid_i = 1'b0;
        repeat (gap - 2) tick();
    endtask

    task automatic checkOutput();
        exp_t e;
        e = exp_q.pop_front();
        n_vec++;
        if (vdata_o !== e.word || cyc != e.cyc) begin
            n_fail++;
            $display("[TB] FAIL pixel: got %h at cycle %0d, want %h at cycle %0d",
                     vdata_o, cyc, e.word, e.cyc);
        end
    endtask

    task automatic checkSignal(input string name, input logic [24:0] act, input logic [24:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    always @(negedge VCLK) begin
        if (!RST && vdata_valid_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL unexpected_output: got %h at cycle %0d, want no pulse",
                         vdata_o, cyc);
            end else begin
                checkOutput();
            end
        end
    end

    initial begin
        logic [3:0] rs;
        logic [6:0] rr, rg, rb;

        RST           = 1'b1;
        gamma_en_i    = 1'b0;
        gamma_page_i  = 3'd0;
        lut_we_i      = 1'b0;
        lut_addr_i    = '0;
        lut_data_i    = '0;
        vdata_valid_i = 1'b0;
        vdata_i       = '0;

        repeat (3) tick();
        checkSignal("reset_valid", {24'd0, vdata_valid_o}, 25'd0);
        checkSignal("reset_data", vdata_o, 25'd0);
        checkSignal("reset_overrun", {24'd0, overrun_o}, 25'd0);
        RST = 1'b0;

        for (int i = 0; i < 128; i++) begin
            tick();
            lut_we_i   = 1'b1;
            lut_addr_i = {3'd2, 7'(i)};
            lut_data_i = 7'(i) ^ 7'h7F;
        end
        for (int i = 0; i < 128; i++) begin
            tick();
            lut_addr_i = {3'd5, 7'(i)};
            lut_data_i = 7'(i + 1);
        end
        tick();
        lut_we_i = 1'b0;

        applyStimulus(pix(4'hF, 7'h10, 7'h20, 7'h7F), 1'b1, pix(4'hF, 7'h10, 7'h20, 7'h7F), 8);
        checkSignal("overrun_idle", {24'd0, overrun_o}, 25'd0);

        gamma_en_i   = 1'b1;
        gamma_page_i = 3'd2;
        applyStimulus(pix(4'hF, 7'h05, 7'h06, 7'h07), 1'b1, pix(4'hF, 7'h05, 7'h06, 7'h07), 3);
        applyStimulus(pix(4'h7, 7'h00, 7'h00, 7'h00), 1'b1, pix(4'h7, 7'h7F, 7'h7F, 7'h7F), 3);
        applyStimulus(pix(4'h5, 7'h01, 7'h40, 7'h7E), 1'b1, pix(4'h5, 7'h7E, 7'h3F, 7'h01), 3);

        gamma_page_i = 3'd5;
        applyStimulus(pix(4'h2, 7'h10, 7'h7F, 7'h00), 1'b1, pix(4'h2, 7'h6F, 7'h00, 7'h7F), 3);
        applyStimulus(pix(4'hA, 7'h10, 7'h7F, 7'h00), 1'b1, pix(4'hA, 7'h6F, 7'h00, 7'h7F), 3);
        applyStimulus(pix(4'h0, 7'h10, 7'h7F, 7'h00), 1'b1, pix(4'h0, 7'h11, 7'h00, 7'h01), 3);
        applyStimulus(pix(4'h3, 7'h7F, 7'h22, 7'h33), 1'b1, pix(4'h3, 7'h00, 7'h23, 7'h34), 8);

        applyStimulus(pix(4'h1, 7'h11, 7'h22, 7'h33), 1'b0, '0, 2);
        applyStimulus(pix(4'h1, 7'h01, 7'h02, 7'h03), 1'b1, pix(4'h1, 7'h02, 7'h03, 7'h04), 10);
        checkSignal("overrun_set", {24'd0, overrun_o}, 25'd1);

        for (int i = 0; i < 16; i++) begin
            rs = 4'($urandom_range(0, 15));
            rr = 7'($urandom_range(0, 127));
            rg = 7'($urandom_range(0, 127));
            rb = 7'($urandom_range(0, 127));
            applyStimulus(pix(rs, rr, rg, rb), 1'b1,
                          pix(rs, rr + 7'd1, rg + 7'd1, rb + 7'd1), 3);
        end
        repeat (10) tick();
        checkSignal("overrun_sticky", {24'd0, overrun_o}, 25'd1);

        applyStimulus(pix(4'h0, 7'h12, 7'h34, 7'h56), 1'b0, '0, 5);
        RST = 1'b1;
        tick();
        checkSignal("midreset_valid", {24'd0, vdata_valid_o}, 25'd0);
        checkSignal("midreset_data", vdata_o, 25'd0);
        checkSignal("midreset_overrun", {24'd0, overrun_o}, 25'd0);
        repeat (2) tick();
        RST = 1'b0;
        repeat (8) tick();
        checkSignal("post_reset_data", vdata_o, 25'd0);

        gamma_page_i = 3'd2;
        applyStimulus(pix(4'hF, 7'h01, 7'h40, 7'h7E), 1'b1, pix(4'hF, 7'h01, 7'h40, 7'h7E), 3);
        applyStimulus(pix(4'h6, 7'h01, 7'h40, 7'h7E), 1'b1, pix(4'h6, 7'h7E, 7'h3F, 7'h01), 3);
        gamma_page_i = 3'd5;
        applyStimulus(pix(4'hF, 7'h10, 7'h7F, 7'h00), 1'b1, pix(4'hF, 7'h6F, 7'h00, 7'h7F), 3);
        applyStimulus(pix(4'h0, 7'h10, 7'h7F, 7'h00), 1'b1, pix(4'h0, 7'h11, 7'h00, 7'h01), 3);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        repeat (4) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d pixels outstanding, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/gamma_lut_mc.md
# gamma_lut_mc

Parametrised, time-multiplexed gamma-correction stage for the PPU video path with a run-time writable lookup table. Per pixel it walks NUM_CH colour channels through one shared LUT read port, re-assembles the corrected pixel, and delays the sync bits to match. The page and bypass selection is latched only at frame start so the picture never tears. It sits between the video input demux and the scaler, in the slot of the fixed-ROM gamma stage, and replaces it.

## Interface
Parameters:
- COLOR_W, 7: bits per colour channel; LUT index and data width.
- NUM_CH, 3: channels per pixel; ch0 is red on the N64 path.
- SYNC_W, 4: sync bits carried alongside the pixel.
- PAGE_W, 3: LUT page select width; 2^PAGE_W gamma curves.
- VSYNC_BIT, 3: index of the active-low vsync bit inside the sync field.

Ports:
- VCLK  in  1  video clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- gamma_en_i  in  1  1 = apply LUT, 0 = bypass.
- gamma_page_i  in  PAGE_W  requested LUT page.
- lut_we_i  in  1  LUT write strobe, one word per cycle.
- lut_addr_i  in  PAGE_W+COLOR_W  write address {page, index}.
- lut_data_i  in  COLOR_W  write data.
- vdata_valid_i  in  1  one-cycle pulse marking the first cycle of a pixel.
- vdata_i  in  SYNC_W+NUM_CH*COLOR_W  {sync, ch0, ch1, …, ch(N-1)}, MSB first. Held stable from the valid pulse until the next one.
- vdata_valid_o  out  1  one-cycle pulse: vdata_o carries a new pixel.
- vdata_o  out  SYNC_W+NUM_CH*COLOR_W  corrected pixel, same layout as vdata_i.
- overrun_o  out  1  sticky: a pixel was aborted by an early valid pulse.

## Operation
Channel sequencer:
- On vdata_valid_i, a counter loads 0 and ch0 is selected as the LUT index.
- The counter then steps one channel per cycle up to NUM_CH-1 and stops there. It does not wrap.

LUT:
- Dual-port RAM of 2^(PAGE_W+COLOR_W) x COLOR_W words.
- Read port: address {active_page, index}, 2-cycle registered read.
- Write port: independent of the read port, written when lut_we_i=1.
- Read-during-write to the same address returns the old data.
- RST does not clear the LUT. Contents are undefined until software writes them.

Frame-synchronous config:
- Shadow registers active_en and active_page load from gamma_en_i and gamma_page_i on a valid pixel whose vsync bit is 0 when the previous valid pixel's vsync bit was 1.
- Between those loads, changes on the config inputs have no effect.

Bypass:
- When active_en=0, the raw channel value is passed through a delay line of the same length as the LUT read, so latency is unchanged.

Collector:
- Corrected channel k is written into its slice of the output-assembly register.
- The sync bits are delayed to align with ch0.
- When the last channel arrives, the whole word is transferred to vdata_o and vdata_valid_o pulses.
- vdata_o holds its value between pulses.

Overrun:
- If vdata_valid_i re-asserts fewer than NUM_CH cycles after the previous pulse, the unfinished pixel is dropped and produces no vdata_valid_o.
- overrun_o is set and stays set until RST.
- The new pixel is processed normally.

## Timing
Latency and throughput:
- A valid pulse in cycle t gives vdata_valid_o=1 in cycle t+NUM_CH+3. For NUM_CH=3 that is t+6.
- Minimum pulse spacing is NUM_CH cycles, which gives full throughput. Larger spacing is allowed.

Config and LUT write visibility:
- A shadow-config load on the pixel at t applies to that pixel's ch0 and every later channel.
- A LUT write at edge e is visible to reads issued in the cycle after e.

Reset:
- RST=1 forces vdata_valid_o=0, vdata_o=0, overrun_o=0, active_en=0 (bypass), active_page=0, and the counters to idle.
- In-flight pixels are discarded.
- After RST falls, vdata_valid_o stays low until t+NUM_CH+3 of the first new valid pulse.

Simultaneous events:
- A LUT write to the active page during active reads is allowed. Each read returns either the old or the new word, as the read-during-write rule above defines.
- An overrun on the same pixel as a vsync edge still performs the config load.

## Test plan
- Bypass after reset: RST pulse, then pixel {sync=4'hF, R=7'h10, G=7'h20, B=7'h7F} at t → vdata_valid_o at t+6 with vdata_o identical to the input; overrun_o=0.
- LUT path: write page 2 as index XOR 7'h7F; set en=1, page=2; send a vsync 1→0 pixel, then pixel {R=7'h01, G=7'h40, B=7'h7E} → output {7'h7E, 7'h3F, 7'h01}, sync matched.
- Frame sync: change page 2→5 mid-frame → following pixels still use page 2 until the next vsync falling pixel, then switch to page 5.
- Overrun: valid pulses at t and t+2 → exactly one vdata_valid_o, at t+8, carrying the second pixel; overrun_o=1 from then until RST.
- Back-to-back: 16 pixels at spacing 3 with random data → 16 output pulses, spacing 3, each matching the reference model.
- Reset mid-pixel: assert RST at t+4 → no output for that pixel; all outputs 0; LUT contents are preserved across the reset.
